// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequences the two cascaded line buffers (lb0 -> lb1) that
// feed a 3x3 Sobel window. It tracks the raster position of accepted pixels,
// drives the buffer write enables, clears the buffers at the start of each
// frame, and flags every position where a full 3x3 neighbourhood is present.
// Optional feature macro: SOBEL_WIN_TAGS_EN adds sof_o/eol_o window tags.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       lb_rst_o,
  output logic [7:0] lb_data_o,
  output logic       lb0_we_o,
  output logic       lb1_we_o,
  input  logic       lb0_done_i,
  input  logic       lb1_done_i,
  output logic       win_valid_o,
  output logic [9:0] row_o,
  output logic [9:0] col_o,
  output logic       busy_o,
  output logic       frame_done_o,
`ifdef SOBEL_WIN_TAGS_EN
  output logic       sof_o,
  output logic       eol_o,
`endif
  output logic       err_o
);

  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);
  localparam logic [9:0] ROW_TWO  = 10'd2;
  localparam logic [9:0] COL_TWO  = 10'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FILL0 = 3'd2,
    S_FILL1 = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     r_state;
  logic       r_ready;
  logic       r_lb_rst;
  logic       r_busy;
  logic       r_frame_done;
  logic       r_err;
  logic [9:0] r_row;
  logic [9:0] r_col;
  logic       r_win_vld;
  logic [9:0] r_win_row;
  logic [9:0] r_win_col;
`ifdef SOBEL_WIN_TAGS_EN
  logic       r_sof;
  logic       r_eol;
`endif

  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_win;
  logic w_primed;

  assign w_accept   = valid_i & r_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_win      = w_accept & (r_row >= ROW_TWO) & (r_col >= COL_TWO);
  // lb1 only takes pixels once the first line has been captured in lb0
  assign w_primed   = (r_state == S_FILL1) | (r_state == S_RUN);

  assign lb_data_o    = data_i;
  assign lb0_we_o     = w_accept;
  assign lb1_we_o     = w_accept & lb0_done_i & w_primed;
  assign ready_o      = r_ready;
  assign lb_rst_o     = r_lb_rst;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;
  assign win_valid_o  = r_win_vld;
  assign row_o        = r_win_row;
  assign col_o        = r_win_col;
`ifdef SOBEL_WIN_TAGS_EN
  assign sof_o        = r_sof;
  assign eol_o        = r_eol;
`endif

  // Frame sequencer: state, raster counters, registered control outputs, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_lb_rst     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
    end else begin
      r_lb_rst     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state  <= S_CLR;
            r_lb_rst <= 1'b1;
            r_busy   <= 1'b1;
            r_row    <= '0;
            r_col    <= '0;
          end
        end
        S_CLR: begin
          r_state <= S_FILL0;
          r_ready <= 1'b1;
        end
        S_FILL0: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col   <= '0;
              r_row   <= 10'd1;
              r_state <= S_FILL1;
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end
        S_FILL1: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col   <= '0;
              r_row   <= ROW_TWO;
              r_state <= S_RUN;
              if (!lb0_done_i) r_err <= 1'b1;
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            // the very first pixel of row 2 may still see lb1 completing its line
            if (!lb1_done_i && !((r_row == ROW_TWO) && (r_col == '0))) r_err <= 1'b1;
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_state      <= S_DONE;
                r_ready      <= 1'b0;
                r_frame_done <= 1'b1;
              end else begin
                r_row <= r_row + 10'd1;
              end
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Window flag: one cycle after an accept that completes a 3x3 neighbourhood
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_vld <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
`ifdef SOBEL_WIN_TAGS_EN
      r_sof     <= 1'b0;
      r_eol     <= 1'b0;
`endif
    end else begin
      r_win_vld <= w_win;
      if (w_win) begin
        r_win_row <= r_row;
        r_win_col <= r_col;
      end
`ifdef SOBEL_WIN_TAGS_EN
      r_sof <= w_win & (r_row == ROW_TWO) & (r_col == COL_TWO);
      r_eol <= w_win & w_col_last;
`endif
    end
  end

endmodule
